// File: rtl/br_pred_gshare_btb_if.sv
// Fetch-lookup and execute-resolve signal bundle between the pipeline and the branch predictor.
interface br_pred_gshare_btb_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned GHR_BITS = 8
);
    logic                fetch_unused_dummy;
    logic [XLEN-1:0]     if_pc;
    logic                if_advance;
    logic                pred_taken;
    logic [XLEN-1:0]     pred_target;
    logic [GHR_BITS-1:0] pred_ghr;

    logic                ex_valid;
    logic                ex_is_branch;
    logic                ex_is_jump;
    logic [XLEN-1:0]     ex_pc;
    logic                ex_taken;
    logic [XLEN-1:0]     ex_target;
    logic                ex_pred_taken;
    logic [XLEN-1:0]     ex_pred_target;
    logic [GHR_BITS-1:0] ex_ghr;
    logic                mispredict;
    logic [XLEN-1:0]     redirect_pc;

    // Pipeline side: drives fetch PC and resolved control flow, consumes predictions.
    modport master (
        output if_pc, if_advance,
        output ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_taken, ex_target,
        output ex_pred_taken, ex_pred_target, ex_ghr,
        input  pred_taken, pred_target, pred_ghr, mispredict, redirect_pc
    );

    // Predictor side.
    modport slave (
        input  if_pc, if_advance,
        input  ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_taken, ex_target,
        input  ex_pred_taken, ex_pred_target, ex_ghr,
        output pred_taken, pred_target, pred_ghr, mispredict, redirect_pc
    );
endinterface

// File: rtl/br_pred_gshare_btb.sv
// Direct-mapped BTB plus 2-bit counter BHT branch predictor with static, bimodal or gshare indexing.
// Lookup is combinational on if_pc; resolved EX control flow updates tables and the speculative GHR.
module br_pred_gshare_btb #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BTB_ENTRIES = 64,
    parameter int unsigned BHT_ENTRIES = 256,
    parameter int unsigned GHR_BITS    = 8,
    parameter int unsigned MODE        = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    br_pred_gshare_btb_if.slave  bus
);
    localparam int unsigned BTB_IW = $clog2(BTB_ENTRIES);
    localparam int unsigned BHT_IW = $clog2(BHT_ENTRIES);
    localparam int unsigned TAG_W  = XLEN - BTB_IW - 2;

    typedef struct packed {
        logic             valid;
        logic             is_jump;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
    } btb_entry_t;

    btb_entry_t          btb_q [BTB_ENTRIES];
    logic [1:0]          bht_q [BHT_ENTRIES];
    logic [GHR_BITS-1:0] ghr_q, ghr_d;

    logic [BTB_IW-1:0]   if_btb_idx, ex_btb_idx;
    logic [BHT_IW-1:0]   if_bht_idx, ex_bht_idx;
    btb_entry_t          if_entry;
    logic                if_hit;
    logic [1:0]          if_ctr, ex_ctr, ex_ctr_nxt;
    logic                pred_taken_c;
    logic                ex_cf, ex_wrong, mispredict_c;
    logic                unused_pc_lsbs;

    assign unused_pc_lsbs = ^{bus.if_pc[1:0], bus.ex_pc[1:0]};

    // Gshare folds the (zero-extended) history into the PC-derived counter index.
    function automatic logic [BHT_IW-1:0] bht_index(input logic [XLEN-1:0] pc,
                                                    input logic [GHR_BITS-1:0] ghr);
        logic [BHT_IW-1:0] idx;
        idx = pc[BHT_IW+1:2];
        if (MODE == 2) idx = idx ^ BHT_IW'(ghr);
        return idx;
    endfunction

    // Fetch-side lookup.
    always_comb begin
        if_btb_idx   = bus.if_pc[BTB_IW+1:2];
        if_entry     = btb_q[if_btb_idx];
        if_hit       = if_entry.valid && (if_entry.tag == bus.if_pc[XLEN-1:BTB_IW+2]);
        if_bht_idx   = bht_index(bus.if_pc, ghr_q);
        if_ctr       = bht_q[if_bht_idx];
        pred_taken_c = (MODE != 0) && !rst && if_hit && (if_entry.is_jump || if_ctr[1]);
    end

    assign bus.pred_taken  = pred_taken_c;
    assign bus.pred_target = pred_taken_c ? if_entry.target : bus.if_pc + XLEN'(4);
    assign bus.pred_ghr    = ghr_q;

    // Execute-side resolve.
    always_comb begin
        ex_cf        = bus.ex_valid && (bus.ex_is_branch || bus.ex_is_jump);
        ex_wrong     = (bus.ex_taken != bus.ex_pred_taken) ||
                       (bus.ex_taken && (bus.ex_target != bus.ex_pred_target));
        mispredict_c = ex_cf && ex_wrong;
    end

    assign bus.mispredict  = mispredict_c;
    assign bus.redirect_pc = bus.ex_taken ? bus.ex_target : bus.ex_pc + XLEN'(4);

    // Speculative history: a mispredict restores the history carried with the instruction.
    always_comb begin
        ghr_d = ghr_q;
        if (mispredict_c && bus.ex_is_branch) begin
            ghr_d = GHR_BITS'({bus.ex_ghr, bus.ex_taken});
        end else if (mispredict_c) begin
            ghr_d = bus.ex_ghr;
        end else if (bus.if_advance && if_hit && !if_entry.is_jump) begin
            ghr_d = GHR_BITS'({ghr_q, pred_taken_c});
        end
    end

    // Saturating counter for the resolved branch.
    always_comb begin
        ex_btb_idx = bus.ex_pc[BTB_IW+1:2];
        ex_bht_idx = bht_index(bus.ex_pc, bus.ex_ghr);
        ex_ctr     = bht_q[ex_bht_idx];
        ex_ctr_nxt = ex_ctr;
        if (bus.ex_taken) begin
            if (ex_ctr != 2'd3) ex_ctr_nxt = ex_ctr + 2'd1;
        end else begin
            if (ex_ctr != 2'd0) ex_ctr_nxt = ex_ctr - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
            for (int i = 0; i < int'(BTB_ENTRIES); i++) btb_q[i] <= '0;
            for (int i = 0; i < int'(BHT_ENTRIES); i++) bht_q[i] <= 2'b01;
        end else begin
            ghr_q <= ghr_d;
            if (MODE != 0) begin
                if (bus.ex_valid && bus.ex_is_branch) bht_q[ex_bht_idx] <= ex_ctr_nxt;
                if (bus.ex_valid && bus.ex_taken) begin
                    btb_q[ex_btb_idx] <= '{valid:   1'b1,
                                           is_jump: bus.ex_is_jump,
                                           tag:     bus.ex_pc[XLEN-1:BTB_IW+2],
                                           target:  bus.ex_target};
                end
            end
        end
    end
endmodule

// File: tb/tb_br_pred_gshare_btb.sv
// Scoreboard bench: one instance per MODE driven in lockstep, checked against a table-level reference model.
module tb_br_pred_gshare_btb;
    localparam int unsigned XLEN = 32;
    localparam int unsigned BTB  = 16;
    localparam int unsigned BHT  = 64;
    localparam int unsigned G    = 6;
    localparam int unsigned GMSK = (1 << G) - 1;

    typedef struct {
        int          m;
        bit          chk_ghr;
        logic        pt;
        logic [31:0] ptgt;
        logic [G-1:0] pghr;
        logic        mp;
        logic [31:0] rpc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         s_rst = 1'b1;
    logic [31:0]  s_if_pc = '0;
    logic         s_if_adv = 1'b0;
    logic         s_ex_valid = 1'b0, s_ex_br = 1'b0, s_ex_jmp = 1'b0, s_ex_taken = 1'b0, s_ex_ptk = 1'b0;
    logic [31:0]  s_ex_pc = '0, s_ex_tgt = '0, s_ex_ptgt = '0;
    logic [G-1:0] s_ex_ghr = '0;

    logic         o_pt   [3];
    logic [31:0]  o_ptgt [3];
    logic [G-1:0] o_pghr [3];
    logic         o_mp   [3];
    logic [31:0]  o_rpc  [3];

    genvar g;
    for (g = 0; g < 3; g++) begin : g_dut
        br_pred_gshare_btb_if #(.XLEN(XLEN), .GHR_BITS(G)) bus ();
        assign bus.if_pc          = s_if_pc;
        assign bus.if_advance     = s_if_adv;
        assign bus.ex_valid       = s_ex_valid;
        assign bus.ex_is_branch   = s_ex_br;
        assign bus.ex_is_jump     = s_ex_jmp;
        assign bus.ex_pc          = s_ex_pc;
        assign bus.ex_taken       = s_ex_taken;
        assign bus.ex_target      = s_ex_tgt;
        assign bus.ex_pred_taken  = s_ex_ptk;
        assign bus.ex_pred_target = s_ex_ptgt;
        assign bus.ex_ghr         = s_ex_ghr;
        assign o_pt[g]   = bus.pred_taken;
        assign o_ptgt[g] = bus.pred_target;
        assign o_pghr[g] = bus.pred_ghr;
        assign o_mp[g]   = bus.mispredict;
        assign o_rpc[g]  = bus.redirect_pc;
        br_pred_gshare_btb #(.XLEN(XLEN), .BTB_ENTRIES(BTB), .BHT_ENTRIES(BHT),
                             .GHR_BITS(G), .MODE(g)) dut (
            .clk (clk),
            .rst (s_rst),
            .bus (bus)
        );
    end

    // Reference model: BTB slots remember the word address of the owner instruction.
    bit          mv   [3][BTB];
    int unsigned mwa  [3][BTB];
    logic [31:0] mtgt [3][BTB];
    bit          mj   [3][BTB];
    int          mc   [3][BHT];
    int unsigned mghr [3];
    bit          model_valid = 1'b0;

    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic apply();
        exp_t e;
        int unsigned slot, bidx, cidx, eslot;
        bit hit, pt, mp;
        mp = s_ex_valid && (s_ex_br || s_ex_jmp) &&
             ((s_ex_taken != s_ex_ptk) || (s_ex_taken && s_ex_tgt != s_ex_ptgt));
        for (int m = 0; m < 3; m++) begin
            slot = (s_if_pc >> 2) % BTB;
            hit  = mv[m][slot] && (mwa[m][slot] == (s_if_pc >> 2));
            bidx = ((s_if_pc >> 2) % BHT) ^ ((m == 2) ? mghr[m] : 0);
            pt   = (m != 0) && !s_rst && hit && (mj[m][slot] || mc[m][bidx] >= 2);
            e.m = m; e.chk_ghr = model_valid; e.pt = pt;
            e.ptgt = pt ? mtgt[m][slot] : s_if_pc + 32'd4;
            e.pghr = G'(mghr[m]);
            e.mp   = mp;
            e.rpc  = s_ex_taken ? s_ex_tgt : s_ex_pc + 32'd4;
            sb.push_back(e);
            if (s_rst) begin
                for (int i = 0; i < int'(BTB); i++) mv[m][i] = 1'b0;
                for (int i = 0; i < int'(BHT); i++) mc[m][i] = 1;
                mghr[m] = 0;
            end else begin
                if (mp && s_ex_br)                        mghr[m] = (s_ex_ghr * 2 + s_ex_taken) & GMSK;
                else if (mp)                              mghr[m] = s_ex_ghr;
                else if (s_if_adv && hit && !mj[m][slot]) mghr[m] = (mghr[m] * 2 + pt) & GMSK;
                if (m != 0 && s_ex_valid && s_ex_br) begin
                    cidx = ((s_ex_pc >> 2) % BHT) ^ ((m == 2) ? s_ex_ghr : 0);
                    if (s_ex_taken) mc[m][cidx] = (mc[m][cidx] == 3) ? 3 : mc[m][cidx] + 1;
                    else            mc[m][cidx] = (mc[m][cidx] == 0) ? 0 : mc[m][cidx] - 1;
                end
                if (m != 0 && s_ex_valid && s_ex_taken) begin
                    eslot = (s_ex_pc >> 2) % BTB;
                    mv[m][eslot] = 1'b1; mwa[m][eslot] = s_ex_pc >> 2;
                    mtgt[m][eslot] = s_ex_tgt; mj[m][eslot] = s_ex_jmp;
                end
            end
        end
        if (s_rst) model_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic adv);
        s_if_pc = pc; s_if_adv = adv;
    endtask

    task automatic resolve(input logic v, input logic br, input logic jmp, input logic [31:0] pc,
                           input logic tk, input logic [31:0] tgt, input logic ptk,
                           input logic [31:0] ptgt, input logic [G-1:0] gh);
        s_ex_valid = v; s_ex_br = br; s_ex_jmp = jmp; s_ex_pc = pc; s_ex_taken = tk;
        s_ex_tgt = tgt; s_ex_ptk = ptk; s_ex_ptgt = ptgt; s_ex_ghr = gh;
    endtask

    task automatic idle_ex();
        resolve(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, '0);
    endtask

    task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s mode%0d t=%0t: got %h expected %h", nm, m, $time, act, exp);
        end
    endtask

    // Monitor: every group pushed before the edge is checked mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pred_taken",  e.m, 32'(o_pt[e.m]),   32'(e.pt));
            chk("pred_target", e.m, o_ptgt[e.m],       e.ptgt);
            chk("mispredict",  e.m, 32'(o_mp[e.m]),   32'(e.mp));
            chk("redirect_pc", e.m, o_rpc[e.m],        e.rpc);
            if (e.chk_ghr) chk("pred_ghr", e.m, 32'(o_pghr[e.m]), 32'(e.pghr));
        end
    end

    function automatic logic [31:0] pick_pc();
        logic [31:0] pool [8];
        pool = '{32'h100, 32'h140, 32'h200, 32'h180, 32'h104, 32'h1C0, 32'h240, 32'h80};
        if ($urandom_range(0, 9) == 0) return {$urandom()} & 32'hFFFF_FFFC;
        return pool[$urandom_range(0, 7)];
    endfunction

    initial begin
        @(posedge clk);
        #1;
        idle_ex(); fetch(32'h100, 1'b0);
        s_rst = 1'b1; apply(); s_rst = 1'b0;

        // Post-reset lookup, then a taken branch allocation and its first hit.
        apply();
        resolve(1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, '0); apply();
        idle_ex(); apply();

        // Counter saturation and decay.
        for (int i = 0; i < 4; i++) begin
            resolve(1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, '0); apply();
        end
        for (int i = 0; i < 2; i++) begin
            resolve(1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, '0); apply();
            idle_ex(); apply();
        end

        // Jump allocation, then same-direction wrong target.
        resolve(1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h400, 1'b0, 32'h204, '0); fetch(32'h200, 1'b0); apply();
        idle_ex(); apply();
        resolve(1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h500, 1'b1, 32'h400, '0); apply();
        idle_ex(); apply();

        // History restore: load via jump mispredict, advance, then a branch mispredict wins over the shift.
        resolve(1'b1, 1'b0, 1'b1, 32'h300, 1'b1, 32'h20, 1'b0, 32'h304, G'(8'hA5)); apply();
        idle_ex(); fetch(32'h100, 1'b1);
        for (int i = 0; i < 3; i++) apply();
        resolve(1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, G'(8'h12)); apply();
        idle_ex(); fetch(32'h100, 1'b0); apply();

        // BTB aliasing, then reset mid-stream.
        resolve(1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, '0); apply();
        resolve(1'b1, 1'b1, 1'b0, 32'h100 + 4 * BTB, 1'b1, 32'h300, 1'b0, 32'h144, '0); apply();
        idle_ex(); fetch(32'h100, 1'b0); apply();
        fetch(32'h100 + 4 * BTB, 1'b0); apply();
        s_rst = 1'b1; apply(); s_rst = 1'b0;
        apply();

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] epc, etgt;
            logic jmp, tk;
            fetch(pick_pc(), 1'($urandom_range(0, 3) != 0));
            epc  = pick_pc();
            etgt = pick_pc();
            jmp  = ($urandom_range(0, 4) == 0);
            tk   = jmp ? 1'b1 : 1'($urandom_range(0, 1));
            resolve(1'($urandom_range(0, 2) != 0), !jmp, jmp, epc, tk, etgt,
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0) ? epc + 32'd4 : (($urandom_range(0, 1) == 1) ? etgt : pick_pc()),
                    G'($urandom()));
            s_rst = ($urandom_range(0, 149) == 0);
            apply();
        end
        s_rst = 1'b0;

        @(negedge clk);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
